// File: rtl/i2c_req_arbiter.sv
// Two-requester arbiter in front of an I2C master: one transaction in flight, XFER_CYCLES+GAP_CYCLES+1 cycles per transfer (1 for a rejected zero address).
// Backpressure: reqN_ready is high only in IDLE for the selected requester; ties alternate away from the last grant.
module i2c_req_arbiter #(
  parameter int XFER_CYCLES = 22,
  parameter int GAP_CYCLES  = 2
) (
  input  logic       clk_in,
  input  logic       reset_in,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [6:0] req0_addr,
  input  logic [7:0] req0_data,
  input  logic       req0_write,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [6:0] req1_addr,
  input  logic [7:0] req1_data,
  input  logic       req1_write,
  output logic       done0,
  output logic       done1,
  output logic       err,
  output logic [7:0] rdata,
  output logic [6:0] mst_addr_out,
  output logic [7:0] mst_data_out,
  output logic       mst_write_out,
  input  logic [7:0] mst_read_in
);

  localparam int CW = ($clog2(XFER_CYCLES + 1) > 6) ? $clog2(XFER_CYCLES + 1) : 6;

  typedef enum logic [1:0] {IDLE, XFER, GAP, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          last_grant;
  logic          cur_id;

  logic          sel_vld;
  logic          sel_id;
  logic [6:0]    sel_addr;
  logic [7:0]    sel_data;
  logic          sel_write;

  always_comb begin
    sel_vld = 1'b0;
    sel_id  = 1'b0;
    if (state == IDLE) begin
      case ({req1_valid, req0_valid})
        2'b01:   begin sel_vld = 1'b1; sel_id = 1'b0;        end
        2'b10:   begin sel_vld = 1'b1; sel_id = 1'b1;        end
        2'b11:   begin sel_vld = 1'b1; sel_id = ~last_grant; end
        default: begin sel_vld = 1'b0; sel_id = 1'b0;        end
      endcase
    end
    sel_addr  = sel_id ? req1_addr  : req0_addr;
    sel_data  = sel_id ? req1_data  : req0_data;
    sel_write = sel_id ? req1_write : req0_write;
  end

  assign req0_ready = !reset_in && sel_vld && !sel_id;
  assign req1_ready = !reset_in && sel_vld &&  sel_id;

  // mst_addr_out doubles as the latched address; it is only nonzero while in XFER.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state         <= IDLE;
      cnt           <= '0;
      last_grant    <= 1'b1;
      cur_id        <= 1'b0;
      mst_addr_out  <= '0;
      mst_data_out  <= '0;
      mst_write_out <= 1'b0;
      rdata         <= '0;
      err           <= 1'b0;
      done0         <= 1'b0;
      done1         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done0 <= 1'b0;
          done1 <= 1'b0;
          err   <= 1'b0;
          if (sel_vld) begin
            last_grant    <= sel_id;
            cur_id        <= sel_id;
            mst_data_out  <= sel_data;
            mst_write_out <= sel_write;
            if (sel_addr != 7'd0) begin
              mst_addr_out <= sel_addr;
              cnt          <= CW'(XFER_CYCLES - 1);
              state        <= XFER;
            end else begin
              err   <= 1'b1;
              done0 <= !sel_id;
              done1 <= sel_id;
              state <= DONE;
            end
          end
        end
        XFER: begin
          if (cnt == '0) begin
            mst_addr_out <= '0;
            cnt          <= CW'(GAP_CYCLES - 1);
            state        <= GAP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        GAP: begin
          if (cnt == '0) begin
            rdata <= mst_read_in;
            err   <= 1'b0;
            done0 <= !cur_id;
            done1 <= cur_id;
            state <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          done0 <= 1'b0;
          done1 <= 1'b0;
          err   <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Scoreboarded bench for i2c_req_arbiter: driver predicts grants and completions, monitor compares every cycle.
module tb_i2c_req_arbiter;
  localparam int XC = 22;
  localparam int GC = 2;

  logic       clk_in = 1'b0;
  logic       reset_in;
  logic       req0_valid, req1_valid, req0_ready, req1_ready;
  logic [6:0] req0_addr, req1_addr;
  logic [7:0] req0_data, req1_data;
  logic       req0_write, req1_write;
  logic       done0, done1, err;
  logic [7:0] rdata;
  logic [6:0] mst_addr_out;
  logic [7:0] mst_data_out;
  logic       mst_write_out;
  logic [7:0] mst_read_in;

  i2c_req_arbiter #(.XFER_CYCLES(XC), .GAP_CYCLES(GC)) dut (
    .clk_in(clk_in), .reset_in(reset_in),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr),
    .req0_data(req0_data), .req0_write(req0_write),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr),
    .req1_data(req1_data), .req1_write(req1_write),
    .done0(done0), .done1(done1), .err(err), .rdata(rdata),
    .mst_addr_out(mst_addr_out), .mst_data_out(mst_data_out),
    .mst_write_out(mst_write_out), .mst_read_in(mst_read_in)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    bit         id;
    bit         err;
    logic [6:0] addr;
    logic [7:0] data;
    bit         wr;
    logic [7:0] rdata;
    int         acc;
  } exp_t;

  exp_t       sbq[$];
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  bit         mon_en = 1'b0;
  bit         lg = 1'b1;          // model of the last grant
  logic [7:0] last_rd = 8'h00;    // model of the held read byte
  logic [7:0] mon_rdata = 8'h00;
  int         last_acc = 0;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: derives the expected master bus and completion from the oldest outstanding entry.
  always begin
    @(negedge clk_in);
    #2;
    if (mon_en) begin
      int   n;
      int   lat;
      logic [6:0] exp_addr;
      exp_t e;
      n = 0; lat = 0; exp_addr = 7'd0;
      if (sbq.size() > 0) begin
        n   = cyc - sbq[0].acc;
        lat = (sbq[0].addr != 7'd0) ? XC + GC + 1 : 1;
        if (sbq[0].addr != 7'd0 && n >= 1 && n <= XC) exp_addr = sbq[0].addr;
      end
      check(mst_addr_out == exp_addr, "mst_addr", mst_addr_out, exp_addr);
      if (sbq.size() > 0 && sbq[0].addr != 7'd0 && n >= 1 && n <= XC + GC) begin
        check(mst_data_out == sbq[0].data, "mst_data", mst_data_out, sbq[0].data);
        check(mst_write_out == sbq[0].wr, "mst_write", mst_write_out, sbq[0].wr);
      end
      check(!(req0_ready && req1_ready), "ready_excl", {req1_ready, req0_ready}, 2'b00);
      if (sbq.size() > 0 && n >= 1)
        check(!req0_ready && !req1_ready, "ready_busy", {req1_ready, req0_ready}, 2'b00);
      if (done0 || done1) begin
        if (sbq.size() == 0) begin
          check(1'b0, "spurious_done", {done1, done0}, 2'b00);
        end else begin
          e = sbq.pop_front();
          check(done0 == !e.id && done1 == e.id, "done_id", {done1, done0}, e.id ? 2'b10 : 2'b01);
          check(err == e.err, "err", err, e.err);
          check(rdata == e.rdata, "rdata_done", rdata, e.rdata);
          check(n == lat, "latency", n, lat);
          mon_rdata = e.rdata;
        end
      end else begin
        check(rdata == mon_rdata, "rdata_hold", rdata, mon_rdata);
      end
    end
  end

  task automatic issue(input bit v0, input bit v1, input logic [6:0] a0, input logic [6:0] a1,
                       input logic [7:0] d0, input logic [7:0] d1, input bit w0, input bit w1,
                       input logic [7:0] rd, input bit hold);
    exp_t e;
    bit   w;
    @(negedge clk_in);
    req0_valid = v0; req0_addr = a0; req0_data = d0; req0_write = w0;
    req1_valid = v1; req1_addr = a1; req1_data = d1; req1_write = w1;
    mst_read_in = rd;
    #1;
    w = (v0 && v1) ? ~lg : v1;
    check(req0_ready == !w && req1_ready == w, "ready_sel", {req1_ready, req0_ready}, w ? 2'b10 : 2'b01);
    lg = w;
    e.id   = w;
    e.addr = w ? a1 : a0;
    e.data = w ? d1 : d0;
    e.wr   = w ? w1 : w0;
    e.err  = (e.addr == 7'd0);
    if (!e.err) last_rd = rd;
    e.rdata = last_rd;
    e.acc   = cyc;
    last_acc = cyc;
    sbq.push_back(e);
    if (!hold) begin
      @(negedge clk_in);
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_addr = 7'($urandom); req1_addr = 7'($urandom);
      req0_data = 8'($urandom); req1_data = 8'($urandom);
      req0_write = 1'($urandom); req1_write = 1'($urandom);
    end
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 60; k++) begin
      @(negedge clk_in);
      #3;
      if (sbq.size() == 0) break;
    end
    if (sbq.size() != 0) begin
      check(1'b0, "done_timeout", sbq.size(), 0);
      sbq.delete();
    end
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    mon_en = 1'b0;
    reset_in = 1'b1;
    #1;
    check(mst_addr_out == 7'd0, "rst_mst_addr", mst_addr_out, 0);
    check(!req0_ready && !req1_ready, "rst_ready", {req1_ready, req0_ready}, 0);
    check(!done0 && !done1 && !err, "rst_done_err", {err, done1, done0}, 0);
    check(rdata == 8'd0, "rst_rdata", rdata, 0);
    check(mst_data_out == 8'd0 && !mst_write_out, "rst_mst_dw", {mst_write_out, mst_data_out}, 0);
    sbq.delete();
    lg = 1'b1; last_rd = 8'h00; mon_rdata = 8'h00;
    repeat (2) @(negedge clk_in);
    req0_valid = 1'b0; req1_valid = 1'b0;
    reset_in = 1'b0;
    mon_en = 1'b1;
  endtask

  initial begin
    reset_in = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_addr = '0; req1_addr = '0; req0_data = '0; req1_data = '0;
    req0_write = 1'b0; req1_write = 1'b0; mst_read_in = '0;
    do_reset();

    // Tie fairness with both requesters held valid from reset.
    for (int i = 0; i < 4; i++) begin
      issue(1, 1, 7'h10 + 7'(i), 7'h20 + 7'(i), 8'(i), 8'(i + 16), 1'b0, 1'b1, 8'h40 + 8'(i), 1'b1);
      wait_idle();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    issue(1, 0, 7'h50, 7'h00, 8'hA5, 8'h00, 1'b0, 1'b0, 8'h11, 1'b0);
    wait_idle();
    issue(0, 1, 7'h00, 7'h21, 8'h00, 8'h77, 1'b0, 1'b1, 8'h3C, 1'b0);
    wait_idle();
    issue(1, 0, 7'h00, 7'h00, 8'h5A, 8'h00, 1'b1, 1'b0, 8'hEE, 1'b0);
    wait_idle();

    // Reset ten cycles into a transfer: bus drops at once and no completion follows.
    issue(1, 0, 7'h33, 7'h00, 8'h99, 8'h00, 1'b1, 1'b0, 8'h66, 1'b0);
    while (cyc < last_acc + 10) @(negedge clk_in);
    #1;
    check(mst_addr_out == 7'h33, "pre_rst_addr", mst_addr_out, 7'h33);
    req0_valid = 1'b1;
    do_reset();
    repeat (40) @(negedge clk_in);
    issue(1, 0, 7'h44, 7'h00, 8'h12, 8'h00, 1'b0, 1'b0, 8'h81, 1'b0);
    wait_idle();

    for (int i = 0; i < 40; i++) begin
      bit v0, v1;
      int pat;
      pat = $urandom_range(0, 2);
      v0 = (pat != 1);
      v1 = (pat != 0);
      issue(v0, v1,
            ($urandom_range(0, 5) == 0) ? 7'd0 : 7'($urandom_range(1, 127)),
            ($urandom_range(0, 5) == 0) ? 7'd0 : 7'($urandom_range(1, 127)),
            8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
            8'($urandom), 1'($urandom_range(0, 1)));
      wait_idle();
    end
    @(negedge clk_in);
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (5) @(negedge clk_in);
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end
endmodule
